decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - Pipelined RV64IM decode stage between fetch and execute; it generates the 8-bit operation code that the ALU consumes.
// - Accepts a raw 32-bit instruction and its PC over valid/ready, and decodes opcode/funct3/funct7.
// - Emits a registered bundle: op code, register indices, 64-bit sign-extended immediate, shamt and an illegal flag.
// - A 2-entry skid buffer decouples in_ready from out_ready.
// PARAMETERS
// - XLEN       64    datapath width of imm, shamt and pc
// - ILLEGAL_OP 8'hFF op code emitted for undecodable words
// PORTS
// - clk          in   1     single clock, rising edge
// - reset        in   1     asynchronous, active-high
// - flush        in   1     synchronous discard of all held entries
// - in_valid     in   1     fetch offers instruction
// - in_ready     out  1     stage can accept
// - in_instr     in   32    raw instruction word
// - in_pc        in   XLEN  instruction address
// - out_valid    out  1     decoded bundle present
// - out_ready    in   1     execute accepts bundle
// - out_op       out  8     operation code, ALU numbering below
// - out_rs1      out  5     source register index 1
// - out_rs2      out  5     source register index 2
// - out_rd       out  5     destination register index
// - out_imm      out  XLEN  sign-extended immediate (I/S/B/U/J formats)
// - out_shamt    out  XLEN  zero-extended shift amount
// - out_pc       out  XLEN  PC carried through
// - out_illegal  out  1     word not recognised; out_op equals ILLEGAL_OP
// BEHAVIOUR
// - Reset values:
//   - out_valid and all valid bits are 0.
//   - in_ready is 1.
//   - All data outputs are 0.
// - Codes (decimal):
//   - ADD..SLTU 0-9, MUL..REMU 10-17.
//   - ADDI 18, XORI 19, ORI 20, ANDI 21, SLLI 22, SRLI 23, SRAI 24, SLTI 25, SLTIU 26.
//   - ADDIW..SRAW 29-37, MULW..REMUW 38-42.
//   - SB/SH/SW/SD 43-46, BEQ..BGEU 47-52.
//   - JAL 53, JALR 54, LUI 55, AUIPC 56, ECALL 57, EBREAK 58.
//   - LB/LH/LW/LBU/LHU/LWU/LD 59-65.
//   - Codes 27 and 28 are never emitted.
// - Shift amounts:
//   - SLLI/SRLI/SRAI: shamt = instr[25:20]; funct6 must be 000000 or 010000.
//   - *IW shifts: shamt = instr[24:20]; funct7 must be 0000000 or 0100000.
//   - Any other funct6/funct7 value marks the word illegal.
// - Immediate: imm is the format-specific immediate sign-extended to XLEN.
//   - U-type: {instr[31:12], 12'b0}, then sign-extended.
//   - R-type: imm = 0.
// - Field masking: fields unused by the format (rs2 for I-type; rd for S/B) are driven from the raw instr bits.
//   Consumers must ignore them.
// - Illegal words: any unlisted opcode/funct combination sets out_illegal=1 and out_op=ILLEGAL_OP.
//   This includes 32'h0000_0000 and words with instr[1:0] != 2'b11.
// - Latency: 1 cycle from an accepted input to out_valid when the output register is empty or draining.
// - Handshake:
//   - Transfer occurs on valid&&ready.
//   - out_* is held stable while out_valid && !out_ready.
// - Skid buffer: output register plus skid register.
//   - in_ready = !skid_valid (registered, with no combinational path from out_ready).
//   - Input accepted while the output register is held (out_valid && !out_ready) goes to the skid register.
//   - When the output drains, skid moves to output in the same cycle. Order is strictly FIFO.
// - Simultaneous events:
//   - Accept and drain in one cycle with skid empty: the new entry loads the output directly.
//   - Drain with skid full: skid moves to output; the new input is not accepted that cycle (in_ready was 0).
// - Flush:
//   - Next edge clears out_valid and skid_valid.
//   - Input presented in the flush cycle is dropped, even if in_ready=1.
//   - Flush has priority over every other event.
// - Reset mid-operation: all valid bits clear immediately (asynchronously); no partial bundle is emitted after release.
// STRUCTURE
// - Package decode_pkg:
//   - alu_op_e: 8-bit enum holding all codes above plus ILLEGAL_OP.
//   - Opcode constants: OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM.
//   - decoded_t struct for the output bundle.
// - Sub-module decode_comb: purely combinational, instr -> decoded_t. It is instantiated once and is unit-testable alone.
// - decode_stage holds only the output and skid registers, the valid bits and the handshake.
// TESTING
// - ADDI x1,x0,-1: 32'hFFF00093 -> op=18, rd=1, rs1=0, imm=64'hFFFF_FFFF_FFFF_FFFF, illegal=0, one cycle later.
// - SRAI x5,x6,63: 32'h43F35293 -> op=24, shamt=63, rd=5, rs1=6.
// - MULW x3,x1,x2: 32'h022081BB -> op=38, rs1=1, rs2=2, rd=3.
// - Backpressure: out_ready=0, offer 3 words -> 2 are accepted, then in_ready=0 and out_* is held stable.
//   Release out_ready -> all 3 emerge in order with no drop or duplicate.
// - Flush with both entries full: out_valid=0 next cycle and in_ready=1; the word offered in the flush cycle never appears.
// - Illegal: 32'h00000000 and 32'h0200D0B3 (funct7=1 with funct3=5 on OP is DIVU, i.e. legal, op=15);
//   32'h4000C0B3 -> illegal=1, op=8'hFF.
//   Assert reset mid-stream -> out_valid=0 asynchronously.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV64IM decode stage: ALU operation
// numbering, major opcodes and the decoded bundle carried to execute.
package decode_pkg;

   localparam int         XLEN       = 64;
   localparam logic [7:0] ILLEGAL_OP = 8'hFF;

   localparam logic [6:0] OP        = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_32     = 7'h3B;
   localparam logic [6:0] OP_IMM_32 = 7'h1B;
   localparam logic [6:0] LOAD      = 7'h03;
   localparam logic [6:0] STORE     = 7'h23;
   localparam logic [6:0] BRANCH    = 7'h63;
   localparam logic [6:0] JAL       = 7'h6F;
   localparam logic [6:0] JALR      = 7'h67;
   localparam logic [6:0] LUI       = 7'h37;
   localparam logic [6:0] AUIPC     = 7'h17;
   localparam logic [6:0] SYSTEM    = 7'h73;

   // Codes 27 and 28 are deliberately left unused by the ALU numbering.
   typedef enum logic [7:0] {
      ALU_ADD = 8'd0, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_ADDI, ALU_XORI, ALU_ORI, ALU_ANDI,
      ALU_SLLI, ALU_SRLI, ALU_SRAI, ALU_SLTI, ALU_SLTIU,
      ALU_ADDIW = 8'd29, ALU_SLLIW, ALU_SRLIW, ALU_SRAIW,
      ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
      ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW,
      ALU_SB, ALU_SH, ALU_SW, ALU_SD,
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
      ALU_JAL, ALU_JALR, ALU_LUI, ALU_AUIPC, ALU_ECALL, ALU_EBREAK,
      ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_LWU, ALU_LD,
      ALU_ILLEGAL = ILLEGAL_OP
   } alu_op_e;

   typedef struct packed {
      alu_op_e         op;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] shamt;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV64IM instruction decoder: raw word and PC in,
// decoded bundle out. Usable on its own for unit tests.
module decode_comb
   import decode_pkg::*;
(
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   output decoded_t        dec
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt6, shamt5;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];

   assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'h000};
   assign imm_j  = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign shamt6 = {{(XLEN-6){1'b0}}, instr[25:20]};
   assign shamt5 = {{(XLEN-5){1'b0}}, instr[24:20]};

   always_comb begin
      dec     = '0;
      dec.op  = ALU_ILLEGAL;
      dec.rs1 = instr[19:15];
      dec.rs2 = instr[24:20];
      dec.rd  = instr[11:7];
      dec.pc  = pc;
      case (opcode)
         OP: begin
            case (f7)
               7'b000_0000: begin
                  case (f3)
                     3'd0: dec.op = ALU_ADD;
                     3'd1: dec.op = ALU_SLL;
                     3'd2: dec.op = ALU_SLT;
                     3'd3: dec.op = ALU_SLTU;
                     3'd4: dec.op = ALU_XOR;
                     3'd5: dec.op = ALU_SRL;
                     3'd6: dec.op = ALU_OR;
                     default: dec.op = ALU_AND;
                  endcase
               end
               7'b010_0000: begin
                  if (f3 == 3'd0) dec.op = ALU_SUB;
                  else if (f3 == 3'd5) dec.op = ALU_SRA;
               end
               7'b000_0001: dec.op = alu_op_e'(8'(ALU_MUL) + {5'd0, f3});
               default: ;
            endcase
         end
         OP_IMM: begin
            dec.imm = imm_i;
            case (f3)
               3'd0: dec.op = ALU_ADDI;
               3'd2: dec.op = ALU_SLTI;
               3'd3: dec.op = ALU_SLTIU;
               3'd4: dec.op = ALU_XORI;
               3'd6: dec.op = ALU_ORI;
               3'd7: dec.op = ALU_ANDI;
               3'd1: if (instr[31:26] == 6'b000000) begin
                  dec.op    = ALU_SLLI;
                  dec.shamt = shamt6;
               end
               default: begin
                  if (instr[31:26] == 6'b000000) begin
                     dec.op    = ALU_SRLI;
                     dec.shamt = shamt6;
                  end else if (instr[31:26] == 6'b010000) begin
                     dec.op    = ALU_SRAI;
                     dec.shamt = shamt6;
                  end
               end
            endcase
         end
         OP_IMM_32: begin
            dec.imm = imm_i;
            // Word shifts only have a 5-bit shamt, so bit 25 belongs to funct7.
            if (f3 == 3'd0) dec.op = ALU_ADDIW;
            else if (f3 == 3'd1 && f7 == 7'b000_0000) begin
               dec.op    = ALU_SLLIW;
               dec.shamt = shamt5;
            end else if (f3 == 3'd5 && f7 == 7'b000_0000) begin
               dec.op    = ALU_SRLIW;
               dec.shamt = shamt5;
            end else if (f3 == 3'd5 && f7 == 7'b010_0000) begin
               dec.op    = ALU_SRAIW;
               dec.shamt = shamt5;
            end
         end
         OP_32: begin
            case ({f7, f3})
               {7'b000_0000, 3'd0}: dec.op = ALU_ADDW;
               {7'b010_0000, 3'd0}: dec.op = ALU_SUBW;
               {7'b000_0000, 3'd1}: dec.op = ALU_SLLW;
               {7'b000_0000, 3'd5}: dec.op = ALU_SRLW;
               {7'b010_0000, 3'd5}: dec.op = ALU_SRAW;
               {7'b000_0001, 3'd0}: dec.op = ALU_MULW;
               {7'b000_0001, 3'd4}: dec.op = ALU_DIVW;
               {7'b000_0001, 3'd5}: dec.op = ALU_DIVUW;
               {7'b000_0001, 3'd6}: dec.op = ALU_REMW;
               {7'b000_0001, 3'd7}: dec.op = ALU_REMUW;
               default: ;
            endcase
         end
         LOAD: begin
            dec.imm = imm_i;
            case (f3)
               3'd0: dec.op = ALU_LB;
               3'd1: dec.op = ALU_LH;
               3'd2: dec.op = ALU_LW;
               3'd3: dec.op = ALU_LD;
               3'd4: dec.op = ALU_LBU;
               3'd5: dec.op = ALU_LHU;
               3'd6: dec.op = ALU_LWU;
               default: ;
            endcase
         end
         STORE: begin
            dec.imm = imm_s;
            if (!f3[2]) dec.op = alu_op_e'(8'(ALU_SB) + {6'd0, f3[1:0]});
         end
         BRANCH: begin
            dec.imm = imm_b;
            case (f3)
               3'd0: dec.op = ALU_BEQ;
               3'd1: dec.op = ALU_BNE;
               3'd4: dec.op = ALU_BLT;
               3'd5: dec.op = ALU_BGE;
               3'd6: dec.op = ALU_BLTU;
               3'd7: dec.op = ALU_BGEU;
               default: ;
            endcase
         end
         JAL: begin
            dec.imm = imm_j;
            dec.op  = ALU_JAL;
         end
         JALR: begin
            dec.imm = imm_i;
            if (f3 == 3'd0) dec.op = ALU_JALR;
         end
         LUI: begin
            dec.imm = imm_u;
            dec.op  = ALU_LUI;
         end
         AUIPC: begin
            dec.imm = imm_u;
            dec.op  = ALU_AUIPC;
         end
         SYSTEM: begin
            dec.imm = imm_i;
            if (instr == 32'h0000_0073) dec.op = ALU_ECALL;
            else if (instr == 32'h0010_0073) dec.op = ALU_EBREAK;
         end
         default: ;
      endcase
      dec.illegal = (dec.op == ALU_ILLEGAL);
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes fetched words and holds them in an
// output register backed by a one-entry skid register (2-deep FIFO).
module decode_stage
   import decode_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [7:0]      out_op,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_shamt,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   decoded_t dec;
   decoded_t out_q, out_d, skid_q, skid_d;
   logic     out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic     accept, out_free;

   decode_comb u_decode_comb (
      .instr (in_instr),
      .pc    (in_pc),
      .dec   (dec)
   );

   always_comb begin
      accept       = in_valid && !skid_valid_q && !flush;
      out_free     = !out_valid_q || out_ready;
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         // A full skid always wins the output; in_ready was low so nothing new arrives.
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) out_d = dec;
         end
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign in_ready    = !skid_valid_q;
   assign out_valid   = out_valid_q;
   assign out_op      = out_q.op;
   assign out_rs1     = out_q.rs1;
   assign out_rs2     = out_q.rs2;
   assign out_rd      = out_q.rd;
   assign out_imm     = out_q.imm;
   assign out_shamt   = out_q.shamt;
   assign out_pc      = out_q.pc;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode/handshake cases followed by random
// traffic checked against a mask/match instruction table and a FIFO model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0] in_instr;
   logic [63:0] in_pc, out_imm, out_shamt, out_pc;
   logic [7:0]  out_op;
   logic [4:0]  out_rs1, out_rs2, out_rd;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [7:0]  op;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] imm, shamt, pc;
      logic        illegal;
   } exp_t;

   localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5, F_SH6 = 6, F_SH5 = 7;
   localparam logic [31:0] M_R = 32'hFE00707F, M_I = 32'h0000707F, M_SH6 = 32'hFC00707F;
   localparam logic [31:0] M_OPC = 32'h0000007F, M_ALL = 32'hFFFFFFFF;

   logic [31:0] t_mask[$], t_match[$];
   int          t_op[$], t_fmt[$];
   exp_t        q[$];
   logic [7:0]  emitted[$];

   decode_stage dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_imm(out_imm), .out_shamt(out_shamt), .out_pc(out_pc), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input int f7, input int f3, input logic [6:0] opc);
      return (32'(f7) << 25) | (32'(f3) << 12) | {25'd0, opc};
   endfunction

   task automatic add(input logic [31:0] m, input logic [31:0] v, input int op, input int fmt);
      t_mask.push_back(m);
      t_match.push_back(v);
      t_op.push_back(op);
      t_fmt.push_back(fmt);
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v, input int bits);
      longint t;
      t = longint'(v) << (64 - bits);
      return 64'(t >>> (64 - bits));
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] p);
      exp_t e;
      int   f;
      f         = -1;
      e.op      = 8'hFF;
      e.illegal = 1'b1;
      e.rs1     = w[19:15];
      e.rs2     = w[24:20];
      e.rd      = w[11:7];
      e.pc      = p;
      e.imm     = '0;
      e.shamt   = '0;
      for (int k = 0; k < t_mask.size(); k++) begin
         if (f < 0 && (w & t_mask[k]) == t_match[k]) begin
            f         = t_fmt[k];
            e.op      = 8'(t_op[k]);
            e.illegal = 1'b0;
         end
      end
      case (f)
         F_I, F_SH6, F_SH5: e.imm = sx({20'd0, w[31:20]}, 12);
         F_S: e.imm = sx({20'd0, w[31:25], w[11:7]}, 12);
         F_B: e.imm = sx({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
         F_U: e.imm = sx({w[31:12], 12'd0}, 32);
         F_J: e.imm = sx({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
         default: e.imm = '0;
      endcase
      if (f == F_SH6) e.shamt = 64'(w[25:20]);
      if (f == F_SH5) e.shamt = 64'(w[24:20]);
      return e;
   endfunction

   // One clock of traffic: drive, check against the FIFO model at negedge, advance.
   task automatic cycle(input logic v, input logic [31:0] w, input logic [63:0] p,
                        input logic ordy, input logic fl);
      exp_t e;
      int   n;
      in_valid  = v;
      in_instr  = w;
      in_pc     = p;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      n = q.size();
      check("out_valid", {63'd0, out_valid}, {63'd0, n > 0});
      check("in_ready", {63'd0, in_ready}, {63'd0, n < 2});
      if (n > 0) begin
         e = q[0];
         check("op", 64'(out_op), 64'(e.op));
         check("illegal", 64'(out_illegal), 64'(e.illegal));
         check("rs1", 64'(out_rs1), 64'(e.rs1));
         check("rs2", 64'(out_rs2), 64'(e.rs2));
         check("rd", 64'(out_rd), 64'(e.rd));
         check("pc", out_pc, e.pc);
         if (!e.illegal) begin
            check("imm", out_imm, e.imm);
            check("shamt", out_shamt, e.shamt);
         end
      end
      if (fl) q.delete();
      else begin
         if (n > 0 && ordy) begin
            emitted.push_back(out_op);
            $display("[TB] out pc=%h op=%0d illegal=%0b", out_pc, out_op, out_illegal);
            void'(q.pop_front());
         end
         if (v && n < 2) q.push_back(ref_decode(w, p));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] w;
      int          k;

      add(M_R, enc(0, 0, 7'h33), 0, F_R);   add(M_R, enc(32, 0, 7'h33), 1, F_R);
      add(M_R, enc(0, 4, 7'h33), 2, F_R);   add(M_R, enc(0, 6, 7'h33), 3, F_R);
      add(M_R, enc(0, 7, 7'h33), 4, F_R);   add(M_R, enc(0, 1, 7'h33), 5, F_R);
      add(M_R, enc(0, 5, 7'h33), 6, F_R);   add(M_R, enc(32, 5, 7'h33), 7, F_R);
      add(M_R, enc(0, 2, 7'h33), 8, F_R);   add(M_R, enc(0, 3, 7'h33), 9, F_R);
      for (int i = 0; i < 8; i++) add(M_R, enc(1, i, 7'h33), 10 + i, F_R);
      add(M_I, enc(0, 0, 7'h13), 18, F_I);  add(M_I, enc(0, 4, 7'h13), 19, F_I);
      add(M_I, enc(0, 6, 7'h13), 20, F_I);  add(M_I, enc(0, 7, 7'h13), 21, F_I);
      add(M_SH6, enc(0, 1, 7'h13), 22, F_SH6);
      add(M_SH6, enc(0, 5, 7'h13), 23, F_SH6);
      add(M_SH6, enc(32, 5, 7'h13), 24, F_SH6);
      add(M_I, enc(0, 2, 7'h13), 25, F_I);  add(M_I, enc(0, 3, 7'h13), 26, F_I);
      add(M_I, enc(0, 0, 7'h1B), 29, F_I);
      add(M_R, enc(0, 1, 7'h1B), 30, F_SH5);
      add(M_R, enc(0, 5, 7'h1B), 31, F_SH5);
      add(M_R, enc(32, 5, 7'h1B), 32, F_SH5);
      add(M_R, enc(0, 0, 7'h3B), 33, F_R);  add(M_R, enc(32, 0, 7'h3B), 34, F_R);
      add(M_R, enc(0, 1, 7'h3B), 35, F_R);  add(M_R, enc(0, 5, 7'h3B), 36, F_R);
      add(M_R, enc(32, 5, 7'h3B), 37, F_R); add(M_R, enc(1, 0, 7'h3B), 38, F_R);
      for (int i = 4; i < 8; i++) add(M_R, enc(1, i, 7'h3B), 35 + i, F_R);
      for (int i = 0; i < 4; i++) add(M_I, enc(0, i, 7'h23), 43 + i, F_S);
      add(M_I, enc(0, 0, 7'h63), 47, F_B);  add(M_I, enc(0, 1, 7'h63), 48, F_B);
      for (int i = 4; i < 8; i++) add(M_I, enc(0, i, 7'h63), 45 + i, F_B);
      add(M_OPC, 32'h6F, 53, F_J);          add(M_I, enc(0, 0, 7'h67), 54, F_I);
      add(M_OPC, 32'h37, 55, F_U);          add(M_OPC, 32'h17, 56, F_U);
      add(M_ALL, 32'h00000073, 57, F_I);    add(M_ALL, 32'h00100073, 58, F_I);
      add(M_I, enc(0, 0, 7'h03), 59, F_I);  add(M_I, enc(0, 1, 7'h03), 60, F_I);
      add(M_I, enc(0, 2, 7'h03), 61, F_I);  add(M_I, enc(0, 4, 7'h03), 62, F_I);
      add(M_I, enc(0, 5, 7'h03), 63, F_I);  add(M_I, enc(0, 6, 7'h03), 64, F_I);
      add(M_I, enc(0, 3, 7'h03), 65, F_I);

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_op", 64'(out_op), 64'd0);
      check("rst_imm", out_imm, 64'd0);
      check("rst_pc", out_pc, 64'd0);
      check("rst_illegal", 64'(out_illegal), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      cycle(1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0);
      check("addi_valid", 64'(out_valid), 64'd1);
      check("addi_op", 64'(out_op), 64'd18);
      check("addi_rd", 64'(out_rd), 64'd1);
      check("addi_rs1", 64'(out_rs1), 64'd0);
      check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_illegal", 64'(out_illegal), 64'd0);
      cycle(1'b1, 32'h43F35293, 64'h1004, 1'b1, 1'b0);
      check("srai_op", 64'(out_op), 64'd24);
      check("srai_shamt", out_shamt, 64'd63);
      check("srai_rd", 64'(out_rd), 64'd5);
      check("srai_rs1", 64'(out_rs1), 64'd6);
      cycle(1'b1, 32'h022081BB, 64'h1008, 1'b1, 1'b0);
      check("mulw_op", 64'(out_op), 64'd38);
      check("mulw_regs", {49'd0, out_rs1, out_rs2, out_rd}, {49'd0, 5'd1, 5'd2, 5'd3});
      cycle(1'b1, 32'h00000000, 64'h100C, 1'b1, 1'b0);
      check("zero_illegal", {55'd0, out_illegal, out_op}, {55'd0, 1'b1, 8'hFF});
      cycle(1'b1, 32'h0200D0B3, 64'h1010, 1'b1, 1'b0);
      check("divu", {55'd0, out_illegal, out_op}, {55'd0, 1'b0, 8'd15});
      cycle(1'b1, 32'h4000C0B3, 64'h1014, 1'b1, 1'b0);
      check("bad_xor", {55'd0, out_illegal, out_op}, {55'd0, 1'b1, 8'hFF});
      cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

      // Backpressure: three offers, two land, third waits for the drain.
      emitted.delete();
      cycle(1'b1, 32'hFFF00093, 64'h2000, 1'b0, 1'b0);
      cycle(1'b1, 32'h43F35293, 64'h2004, 1'b0, 1'b0);
      cycle(1'b1, 32'h022081BB, 64'h2008, 1'b0, 1'b0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_op", 64'(out_op), 64'd18);
      check("bp_hold_pc", out_pc, 64'h2000);
      cycle(1'b1, 32'h022081BB, 64'h2008, 1'b1, 1'b0);
      cycle(1'b1, 32'h022081BB, 64'h2008, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      check("bp_count", 64'(emitted.size()), 64'd3);
      if (emitted.size() == 3)
         check("bp_order", {40'd0, emitted[0], emitted[1], emitted[2]}, {40'd0, 8'd18, 8'd24, 8'd38});

      // Flush with both entries full, then flush while ready.
      cycle(1'b1, 32'hFFF00093, 64'h3000, 1'b0, 1'b0);
      cycle(1'b1, 32'h43F35293, 64'h3004, 1'b0, 1'b0);
      cycle(1'b1, 32'h022081BB, 64'h3008, 1'b0, 1'b1);
      check("fl_out_valid", 64'(out_valid), 64'd0);
      check("fl_in_ready", 64'(in_ready), 64'd1);
      cycle(1'b1, 32'h022081BB, 64'h300C, 1'b1, 1'b1);
      check("fl_drop_valid", 64'(out_valid), 64'd0);
      emitted.delete();
      cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      check("fl_nothing_out", 64'(emitted.size()), 64'd0);

      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 99) < 85) begin
            k = $urandom_range(0, t_mask.size() - 1);
            w = ($urandom() & ~t_mask[k]) | t_match[k];
         end else begin
            w = $urandom();
         end
         cycle($urandom_range(0, 99) < 70, w, {$urandom(), $urandom()},
               $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
      end

      // Asynchronous reset between clock edges.
      cycle(1'b1, 32'hFFF00093, 64'h4000, 1'b0, 1'b0);
      cycle(1'b1, 32'h43F35293, 64'h4004, 1'b0, 1'b0);
      reset = 1'b1;
      #2;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      cycle(1'b1, 32'h0010_0073, 64'h5000, 1'b1, 1'b0);
      check("ebreak_op", 64'(out_op), 64'd58);
      cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
